vending_machine_multi: RTL

//  Parametrised coin-credit vending controller; successor to the fixed 3-state vendor.

---
 rtl/vending_pkg.sv | 38 +++
 rtl/vm_change_dispenser.sv | 43 ++++
 rtl/vending_machine_multi.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-coin vending controller.
// Coin values are parameters of the top, so coin_value() takes them as arguments.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vm_state_e;

  localparam logic [1:0] COIN_SEL_0 = 2'd0;
  localparam logic [1:0] COIN_SEL_1 = 2'd1;
  localparam logic [1:0] COIN_SEL_2 = 2'd2;
  localparam logic [1:0] COIN_SEL_3 = 2'd3;

  function automatic int unsigned coin_value(input logic [1:0] sel,
                                             input int unsigned v0, input int unsigned v1,
                                             input int unsigned v2, input int unsigned v3);
    case (sel)
      COIN_SEL_0: coin_value = v0;
      COIN_SEL_1: coin_value = v1;
      COIN_SEL_2: coin_value = v2;
      default:    coin_value = v3;
    endcase
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Change hopper interface: counts a loaded surplus down one UNIT per handshake.
// chg_valid is decoded from the counter, so it never drops without a handshake.
module vm_change_dispenser #(
  parameter int unsigned W    = 6,
  parameter int unsigned UNIT = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         chg_valid,
  input  logic         chg_ready,
  output logic [W-1:0] remaining,
  output logic         done
);

  localparam logic [W-1:0] UNIT_C = W'(UNIT);

  logic [W-1:0] cnt_q, cnt_d;

  assign chg_valid = (cnt_q != '0);
  assign remaining = cnt_q;
  // Asserted on the edge whose handshake empties the counter.
  assign done      = chg_valid && chg_ready && (cnt_q == UNIT_C);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (chg_valid && chg_ready) begin
      cnt_d = cnt_q - UNIT_C;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Coin-credit vending controller: four denominations, vend at PRICE, surplus as change.
// Optional refund on cancel is enabled by defining VM_CANCEL_EN.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W  = 6,
  parameter int unsigned PRICE     = 3,
  parameter int unsigned COIN0_VAL = 1,
  parameter int unsigned COIN1_VAL = 2,
  parameter int unsigned COIN2_VAL = 5,
  parameter int unsigned COIN3_VAL = 10,
  parameter int unsigned CHG_UNIT  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  output logic                coin_ready,
`ifdef VM_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                vend,
  output logic                chg_valid,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned MAX_COIN = max4(COIN0_VAL, COIN1_VAL, COIN2_VAL, COIN3_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  if (PRICE - 1 + MAX_COIN >= (2 ** CREDIT_W)) begin : g_chk_width
    $error("vending_machine_multi: CREDIT_W too small for PRICE and largest coin");
  end
  if ((PRICE % CHG_UNIT) != 0 || (COIN0_VAL % CHG_UNIT) != 0 || (COIN1_VAL % CHG_UNIT) != 0 ||
      (COIN2_VAL % CHG_UNIT) != 0 || (COIN3_VAL % CHG_UNIT) != 0) begin : g_chk_unit
    $error("vending_machine_multi: CHG_UNIT must divide PRICE and every coin value");
  end

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] coin_val, sum;
  logic                accept, cancel_req;
  logic                disp_load, disp_done;
  logic [CREDIT_W-1:0] disp_value, disp_remaining;

  assign coin_ready = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign busy       = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign vend       = (state_q == ST_VEND);
  assign credit     = (state_q == ST_CHANGE) ? disp_remaining : credit_q;
  assign accept     = coin_valid && coin_ready;

  always_comb begin
    coin_val = CREDIT_W'(coin_value(coin_sel, COIN0_VAL, COIN1_VAL, COIN2_VAL, COIN3_VAL));
    sum      = accept ? (credit_q + coin_val) : credit_q;
  end

`ifdef VM_CANCEL_EN
  // A coin accepted alongside cancel is counted first, then refunded with the rest.
  assign cancel_req = cancel && coin_ready && (sum != '0);
`else
  assign cancel_req = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    disp_load  = 1'b0;
    disp_value = credit_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel_req) begin
          state_d    = ST_CHANGE;
          disp_load  = 1'b1;
          disp_value = sum;
          credit_d   = '0;
        end else if (accept) begin
          if (sum >= PRICE_C) begin
            state_d  = ST_VEND;
            credit_d = sum - PRICE_C;
          end else begin
            state_d  = ST_COLLECT;
            credit_d = sum;
          end
        end
      end
      ST_VEND: begin
        if (credit_q != '0) begin
          state_d    = ST_CHANGE;
          disp_load  = 1'b1;
          disp_value = credit_q;
          credit_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (disp_done || (disp_remaining == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  vm_change_dispenser #(
    .W    (CREDIT_W),
    .UNIT (CHG_UNIT)
  ) u_disp (
    .clk        (clk),
    .rstn       (rstn),
    .load       (disp_load),
    .load_value (disp_value),
    .chg_valid  (chg_valid),
    .chg_ready  (chg_ready),
    .remaining  (disp_remaining),
    .done       (disp_done)
  );

endmodule
